irq_arbiter: RTL and testbench
==============================

// Module: irq_arbiter
// PURPOSE
//  Interrupt controller between peripheral IRQ lines (buttons, UART rx/tx, timer) and the pipelined CPU core.
//  Latches or samples per-source requests, masks them, and picks one by fixed priority (lowest index wins).
//  Presents that one to the core through a req/ack/done handshake.
//  Memory-mapped config/status registers sit on the core's data bus.
// PARAMETERS
//  N_SRC   4   number of interrupt sources (1..16)
//  ID_W    2   width of int_id; must satisfy 2**ID_W >= N_SRC
// PORTS
//  clk        in   1      system clock
//  rst        in   1      synchronous reset, active-high
//  irq_src    in   N_SRC  raw source lines, already synchronous to clk
//  reg_we     in   1      register write strobe (single cycle)
//  reg_re     in   1      register read strobe
//  reg_addr   in   4      byte address; reg_addr[3:2] selects register
//  reg_wdata  in   32     write data
//  reg_rdata  out  32     read data, registered, valid cycle after reg_re
//  int_req    out  1      interrupt request to core
//  int_id     out  ID_W   source index of the current request/service
//  int_ack    in   1      core has taken the trap for int_id
//  int_done   in   1      core executed return-from-interrupt
// BEHAVIOUR
//  Registers (bits >= N_SRC read 0, writes ignored):
//   0x0 ENABLE  RW  per-source mask, reset 0
//   0x4 PENDING R   pending vector; write-1-to-clear edge bits; level bits ignore writes
//   0x8 TRIGGER RW  1=rising-edge latched, 0=level; reset 0
//   0xC STATUS  R   {27'b0, busy, req, id[2:0]}; id zero-extended/truncated to 3 bits
//  Edge detect: irq_d <= irq_src every cycle, reset 0.
//   A source already high when reset releases counts as an edge one cycle later.
//  pending[i] = TRIGGER[i] ? edge_latch[i] : irq_src[i].
//  edge_latch[i] set on irq_src[i] & ~irq_d[i]. Cleared by PENDING W1C or by int_ack with int_id==i.
//   Set wins over clear in the same cycle.
//  cand = pending & ENABLE; sel = lowest set index of cand.
//  FSM states IDLE, REQ, SERVICE; reset -> IDLE.
//   IDLE: if |cand -> REQ next cycle; int_id <= sel; int_req <= 1 (1 cycle latency from pending).
//   REQ: int_req held 1, int_id stable. The latched id is never preempted by a higher-priority arrival.
//   REQ, int_ack=1 -> SERVICE; int_req <= 0; edge bit of int_id cleared.
//   REQ, latched id no longer in cand (masked, W1C'd, level dropped) and no ack -> IDLE; int_req <= 0.
//   REQ, ack and withdrawal in the same cycle: ack wins.
//   SERVICE: int_req 0, int_id held. int_done -> IDLE; next request no earlier than the cycle after.
//   No nesting: new/higher sources stay pending during SERVICE.
//  int_ack outside REQ and int_done outside SERVICE: ignored.
//  Level source still high after int_done re-requests (the handler must quiet the peripheral).
//  Reset outputs: int_req=0, int_id=0, reg_rdata=0; ENABLE, TRIGGER, edge_latch, irq_d all 0.
//  Reset mid-REQ/SERVICE aborts the request; the core sees int_req=0 the cycle after rst.
//  Reg write and FSM update in the same cycle: the write takes effect for the next cycle's evaluation.
// TESTING
//  1. TRIGGER=0xF, ENABLE=0x6; pulse src1 and src2 same cycle -> int_req next cycle with id=1.
//     After ack+done, id=2 requested.
//  2. ENABLE=0; pulse src0 -> PENDING=0x1, int_req stays 0. Write ENABLE=0x1 -> int_req with id=0.
//  3. REQ on id=3 (edge); write ENABLE=0 before ack -> int_req drops, FSM IDLE, PENDING[3] still 1.
//  4. Level src2 high, ack, done while still high -> re-request id=2 exactly 1 cycle after IDLE.
//  5. Edge on src0 in the same cycle as int_ack for id=0 -> PENDING[0]=1 after ack.
//  6. Assert rst during SERVICE -> int_req=0, int_id=0, ENABLE/TRIGGER=0, STATUS=0 next cycle.

Source files
------------

// File: rtl/irq_arbiter_if.sv
// rtl/irq_arbiter_if.sv - register bus and interrupt handshake between core and irq_arbiter
interface irq_arbiter_if #(
  parameter int ID_W = 2
) ();
  logic            reg_we;
  logic            reg_re;
  logic [3:0]      reg_addr;
  logic [31:0]     reg_wdata;
  logic [31:0]     reg_rdata;
  logic            int_req;
  logic [ID_W-1:0] int_id;
  logic            int_ack;
  logic            int_done;

  modport master (
    output reg_we, reg_re, reg_addr, reg_wdata, int_ack, int_done,
    input  reg_rdata, int_req, int_id
  );

  modport slave (
    input  reg_we, reg_re, reg_addr, reg_wdata, int_ack, int_done,
    output reg_rdata, int_req, int_id
  );
endinterface

// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - fixed-priority interrupt arbiter with req/ack/done handshake to the core
module irq_arbiter #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  irq_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state;
  logic [N_SRC-1:0] enable;
  logic [N_SRC-1:0] trigger;
  logic [N_SRC-1:0] edge_latch;
  logic [N_SRC-1:0] irq_d;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] cand;
  logic [N_SRC-1:0] id_oh;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] ack_clr;
  logic [ID_W-1:0]  sel;
  logic [1:0]       reg_sel;
  logic             id_live;
  logic             ack_take;
  logic             busy;
  logic             unused_ok;

  assign reg_sel   = bus.reg_addr[3:2];
  assign unused_ok = ^{bus.reg_addr[1:0], bus.reg_wdata[31:N_SRC]};

  always_comb begin
    rise    = irq_src & ~irq_d;
    pending = (trigger & edge_latch) | (~trigger & irq_src);
    cand    = pending & enable;

    // Descending scan so the lowest set index is the one left in sel.
    sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (cand[i]) sel = ID_W'(i);
    end

    id_oh = '0;
    for (int i = 0; i < N_SRC; i++) begin
      id_oh[i] = (bus.int_id == ID_W'(i));
    end

    id_live  = |(cand & id_oh);
    ack_take = (state == REQ) && bus.int_ack;
    busy     = (state != IDLE);

    // Only edge-triggered bits hold latched state that W1C may clear.
    w1c = '0;
    if (bus.reg_we && reg_sel == 2'd1) w1c = bus.reg_wdata[N_SRC-1:0] & trigger;

    ack_clr = '0;
    if (ack_take) ack_clr = id_oh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_d      <= '0;
      edge_latch <= '0;
      enable     <= '0;
      trigger    <= '0;
    end else begin
      irq_d      <= irq_src;
      // A new edge wins over any clear arriving in the same cycle.
      edge_latch <= (edge_latch & ~(w1c | ack_clr)) | rise;
      if (bus.reg_we) begin
        case (reg_sel)
          2'd0:    enable  <= bus.reg_wdata[N_SRC-1:0];
          2'd2:    trigger <= bus.reg_wdata[N_SRC-1:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.reg_rdata <= '0;
    end else if (bus.reg_re) begin
      case (reg_sel)
        2'd0:    bus.reg_rdata <= 32'(enable);
        2'd1:    bus.reg_rdata <= 32'(pending);
        2'd2:    bus.reg_rdata <= 32'(trigger);
        default: bus.reg_rdata <= {27'b0, busy, bus.int_req, 3'(bus.int_id)};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bus.int_req <= 1'b0;
      bus.int_id  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|cand) begin
            state       <= REQ;
            bus.int_req <= 1'b1;
            bus.int_id  <= sel;
          end
        end
        REQ: begin
          // Ack is checked first so it beats a simultaneous withdrawal.
          if (bus.int_ack) begin
            state       <= SERVICE;
            bus.int_req <= 1'b0;
          end else if (!id_live) begin
            state       <= IDLE;
            bus.int_req <= 1'b0;
          end
        end
        SERVICE: begin
          if (bus.int_done) state <= IDLE;
        end
        default: begin
          state       <= IDLE;
          bus.int_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// tb/tb_irq_arbiter.sv - scoreboard bench for irq_arbiter
module tb_irq_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] irq_src = 4'h0;

  irq_arbiter_if #(.ID_W(2)) bus ();

  irq_arbiter #(.N_SRC(4), .ID_W(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .irq_src (irq_src),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_rd[$];
  logic [1:0]  exp_req[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  logic re_q  = 1'b0;
  logic req_q = 1'b0;

  always @(posedge clk) begin
    re_q  <= bus.reg_re & ~rst;
    req_q <= bus.int_req;
  end

  // Monitor: any read response or new interrupt request is matched against the queues.
  always @(negedge clk) begin
    if (re_q) begin
      if (exp_rd.size() == 0) check("rd_unexpected", bus.reg_rdata, 32'hdead_beef);
      else check("rd_data", bus.reg_rdata, exp_rd.pop_front());
    end
    if (bus.int_req && !req_q) begin
      if (exp_req.size() == 0) check("req_unexpected", {30'b0, bus.int_id}, 32'hdead_beef);
      else check("req_id", {30'b0, bus.int_id}, {30'b0, exp_req.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    bus.reg_we    = 1'b1;
    bus.reg_addr  = addr;
    bus.reg_wdata = data;
    tick();
    bus.reg_we    = 1'b0;
  endtask

  task automatic rd(input logic [3:0] addr, input logic [31:0] exp);
    exp_rd.push_back(exp);
    bus.reg_re   = 1'b1;
    bus.reg_addr = addr;
    tick();
    bus.reg_re   = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] src);
    irq_src = src;
    tick();
    irq_src = 4'h0;
  endtask

  task automatic wait_req();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus.int_req && n < 20);
    if (!bus.int_req) check("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic ack();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
  endtask

  task automatic done();
    bus.int_done = 1'b1;
    tick();
    bus.int_done = 1'b0;
  endtask

  initial begin
    bus.reg_we = 1'b0; bus.reg_re = 1'b0; bus.reg_addr = 4'h0; bus.reg_wdata = 32'h0;
    bus.int_ack = 1'b0; bus.int_done = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_int_req", {31'b0, bus.int_req}, 32'd0);
    check("rst_int_id", {30'b0, bus.int_id}, 32'd0);
    rd(4'h0, 32'h0);
    rd(4'h8, 32'h0);
    rd(4'hC, 32'h0);

    // Two edges together: lowest index first, then the other after done.
    wr(4'h8, 32'hF);
    wr(4'h0, 32'h6);
    exp_req.push_back(2'd1);
    pulse(4'h6);
    wait_req();
    ack();
    check("t1_req_low_after_ack", {31'b0, bus.int_req}, 32'd0);
    rd(4'hC, 32'h11);
    exp_req.push_back(2'd2);
    done();
    wait_req();
    ack();
    done();
    rd(4'h4, 32'h0);

    // Masked edge stays pending until enabled.
    wr(4'h0, 32'h0);
    pulse(4'h1);
    tick();
    rd(4'h4, 32'h1);
    tick();
    check("t2_masked_no_req", {31'b0, bus.int_req}, 32'd0);
    exp_req.push_back(2'd0);
    wr(4'h0, 32'h1);
    wait_req();
    ack();
    done();

    // Masking the latched id withdraws the request, pending bit survives.
    wr(4'h0, 32'h8);
    exp_req.push_back(2'd3);
    pulse(4'h8);
    wait_req();
    wr(4'h0, 32'h0);
    tick();
    check("t3_withdrawn", {31'b0, bus.int_req}, 32'd0);
    rd(4'h4, 32'h8);
    wr(4'h4, 32'h8);
    rd(4'h4, 32'h0);

    // Level source still high after done re-requests one cycle after IDLE.
    wr(4'h8, 32'hB);
    wr(4'h0, 32'h4);
    exp_req.push_back(2'd2);
    irq_src = 4'h4;
    wait_req();
    ack();
    exp_req.push_back(2'd2);
    done();
    check("t4_idle_cycle", {31'b0, bus.int_req}, 32'd0);
    tick();
    check("t4_rerequest", {31'b0, bus.int_req}, 32'd1);
    check("t4_rerequest_id", {30'b0, bus.int_id}, 32'd2);
    ack();
    irq_src = 4'h0;
    done();

    // New edge in the ack cycle keeps the source pending.
    wr(4'h8, 32'hF);
    wr(4'h0, 32'h1);
    exp_req.push_back(2'd0);
    pulse(4'h1);
    wait_req();
    irq_src = 4'h1;
    ack();
    irq_src = 4'h0;
    rd(4'h4, 32'h1);
    exp_req.push_back(2'd0);
    done();
    wait_req();
    ack();
    done();
    rd(4'h4, 32'h0);

    // Reset while in service.
    wr(4'h0, 32'h2);
    exp_req.push_back(2'd1);
    pulse(4'h2);
    wait_req();
    ack();
    rst = 1'b1;
    tick();
    check("t6_int_req", {31'b0, bus.int_req}, 32'd0);
    check("t6_int_id", {30'b0, bus.int_id}, 32'd0);
    rst = 1'b0;
    rd(4'h0, 32'h0);
    rd(4'h8, 32'h0);
    rd(4'hC, 32'h0);
    repeat (3) tick();

    check("rd_queue_drained", exp_rd.size(), 32'd0);
    check("req_queue_drained", exp_req.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
